vga_capture: RTL and testbench
==============================

# vga_capture

Pixel-side receiver for the 640x480 VGA timing stream driven by the display controller. It samples `hsync`, `vsync`, `valid` and 24-bit RGB on the pixel clock and recovers frame, line and pixel boundaries. It emits a framebuffer write port (x, y, data) and reports lock and timing errors. It sits on loopback and capture paths: a frame checker or framebuffer writer consumes its write port.

## Interface
- `H_ACTIVE`, default 640: pixels per active line.
- `V_ACTIVE`, default 480: active lines per frame.
- `pclk`  in  1  pixel clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `hsync`  in  1  horizontal sync; active-low pulse.
- `vsync`  in  1  vertical sync; active-low pulse.
- `valid`  in  1  data enable; high during active pixels.
- `vga_r`, `vga_g`, `vga_b`  in  8 each  pixel colour.
- `wr_en`  out  1  pixel write strobe.
- `wr_x`  out  10  pixel column, 0..H_ACTIVE-1.
- `wr_y`  out  10  pixel row, 0..V_ACTIVE-1.
- `wr_data`  out  24  {r,g,b}.
- `frame_done`  out  1  one-cycle pulse on completion of a well-formed frame.
- `locked`  out  1  high after one well-formed frame; low after any error.
- `line_err`  out  1  one-cycle pulse: bad line length or missing/extra hsync.
- `frame_err`  out  1  one-cycle pulse: vsync arrived before V_ACTIVE lines completed.
- `frame_cnt`  out  16  count of well-formed frames; wraps 0xFFFF->0.

## Operation
- Stage 1 registers all inputs.
- Stage 2 compares the registered inputs with their previous values to detect edges: vs_fall, hs_fall, de_rise, de_fall.
- States:
  - IDLE: writes suppressed; vs_fall -> WAIT_DE with y=0.
  - WAIT_DE: waits for the first line of the frame; hsync edges are ignored; de_rise -> LINE with x=0.
  - LINE: each cycle with de high writes one pixel.
  - GAP: between lines; counts hs_fall; de_rise -> LINE with x=0.
- Pixel write in LINE: wr_en=1, wr_x=x, wr_y=y, wr_data={r,g,b}, then x++.
- Overrun: pixels with x>=H_ACTIVE are not written (wr_en=0); x saturates at H_ACTIVE+1.
- de_fall in LINE:
  - x!=H_ACTIVE: line_err, locked<=0, -> IDLE.
  - Otherwise, y==V_ACTIVE-1: frame_done, frame_cnt++, locked<=1, -> IDLE.
  - Otherwise: y++, hs count cleared, -> GAP.
- de_rise in GAP with hs count != 1: line_err, locked<=0, -> IDLE.
- vs_fall in WAIT_DE, LINE or GAP: frame_err, locked<=0, restart as a new frame (-> WAIT_DE, y=0, x=0).
- Same-cycle de_fall and vs_fall: the de_fall rules are applied first, then vs_fall.
  - If the line completed the frame: frame_done, then a new frame starts (-> WAIT_DE), with no frame_err.
  - Otherwise: frame_err per the vs_fall rule.
- Writes are issued while `locked`=0; consumers qualify them with `locked`.
- wr_x and wr_y hold their last value when wr_en=0.
- Width rules: x and y are 10 bits; frame_cnt wraps modulo 2^16.

## Timing
- Reset (synchronous) values: state IDLE, x=y=0. All outputs 0: wr_en, wr_x, wr_y, wr_data, frame_done, locked, line_err, frame_err, frame_cnt.
- Reset mid-frame abandons the frame. Capture resumes only after a fresh vs_fall.
- Fixed latency of 2 pclk cycles from input to output. A pixel presented in input cycle n appears on wr_* in cycle n+2.
- Edge-derived pulses appear 2 cycles after the input transition: frame_done, line_err, frame_err.
- locked changes in the same cycle as the frame_done/err pulse that causes it.
- Back-to-back pixels give a contiguous wr_en with no bubbles; wr_x increments by 1 per cycle.
- No backpressure: the consumer must accept one write per cycle.

## Test plan
- Frame after reset: reset, then a nominal 800x525 stream with 640x480 active.
  - The first frame is missed (no vs_fall seen).
  - Frame 2 gives 307200 wr_en cycles, with the last write at (639,479).
  - frame_done fires 2 cycles after the last de_fall; locked=1; frame_cnt=1.
- Latency: a pixel 0x123456 driven as the first active pixel of line 0 -> wr_en=1, wr_x=0, wr_y=0, wr_data=0x123456 exactly 2 cycles later.
- Short line: line 10 has de high for 639 cycles -> line_err pulse, locked=0, IDLE.
  - The next frame captures fully and relocks with frame_cnt incremented.
- Long line: 641-cycle de on line 3 -> 640 writes only (wr_x max 639), then line_err.
- Early vsync: vs_fall after 300 lines -> frame_err, locked=0.
  - The next 480 lines are captured as frame y=0..479, then frame_done.
- Missing hsync / mid-frame reset:
  - A gap between lines with no hsync pulse -> line_err.
  - reset asserted at pixel (100,200) -> all outputs 0 the next cycle; no writes until after the following vs_fall.

Source files
------------

// File: rtl/vga_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_capture                                                  |
// | Description : Pixel-side receiver for a VGA timing stream. Registers the   |
// |               sync/enable/RGB inputs, derives sync and enable edges, and   |
// |               recovers frame/line/pixel boundaries into a framebuffer      |
// |               write port with lock and timing-error reporting.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        valid,
   input  logic [7:0]  vga_r,
   input  logic [7:0]  vga_g,
   input  logic [7:0]  vga_b,
   output logic        wr_en,
   output logic [9:0]  wr_x,
   output logic [9:0]  wr_y,
   output logic [23:0] wr_data,
   output logic        frame_done,
   output logic        locked,
   output logic        line_err,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   // Column count that marks a complete line, the saturation point of the
   // column counter (one past complete, so any overrun reads as "wrong"),
   // and the row index of the final active line.
   localparam logic [9:0] X_FULL = 10'(H_ACTIVE);
   localparam logic [9:0] X_SAT  = 10'(H_ACTIVE + 1);
   localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_DE = 2'd1,
      ST_LINE    = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   // ---------------------------------------------------------------------
   // Stage 1: input registers
   // ---------------------------------------------------------------------
   logic        hs_s1_q, hs_s1_d;
   logic        vs_s1_q, vs_s1_d;
   logic        de_s1_q, de_s1_d;
   logic [23:0] rgb_s1_q, rgb_s1_d;

   // ---------------------------------------------------------------------
   // Stage 2: previous values of the stage-1 registers for edge detection
   // ---------------------------------------------------------------------
   logic        hs_s2_q, hs_s2_d;
   logic        vs_s2_q, vs_s2_d;
   logic        de_s2_q, de_s2_d;

   logic        vs_fall;
   logic        hs_fall;
   logic        de_rise;
   logic        de_fall;

   // ---------------------------------------------------------------------
   // Capture state and registered outputs
   // ---------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [1:0]  hs_cnt_q, hs_cnt_d;

   logic        wr_en_q, wr_en_d;
   logic [9:0]  wr_x_q, wr_x_d;
   logic [9:0]  wr_y_q, wr_y_d;
   logic [23:0] wr_data_q, wr_data_d;
   logic        frame_done_q, frame_done_d;
   logic        locked_q, locked_d;
   logic        line_err_q, line_err_d;
   logic        frame_err_q, frame_err_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic        line_start;
   logic        frame_end;

   // Next values of the two pipeline stages: stage 1 follows the pins,
   // stage 2 follows stage 1.
   always_comb begin
      hs_s1_d  = hsync;
      vs_s1_d  = vsync;
      de_s1_d  = valid;
      rgb_s1_d = {vga_r, vga_g, vga_b};
      hs_s2_d  = hs_s1_q;
      vs_s2_d  = vs_s1_q;
      de_s2_d  = de_s1_q;
   end

   // Pipeline registers; syncs idle high so reset never fakes a falling edge.
   always_ff @(posedge pclk) begin
      if (reset) begin
         hs_s1_q  <= 1'b1;
         vs_s1_q  <= 1'b1;
         de_s1_q  <= 1'b0;
         rgb_s1_q <= 24'h0;
         hs_s2_q  <= 1'b1;
         vs_s2_q  <= 1'b1;
         de_s2_q  <= 1'b0;
      end else begin
         hs_s1_q  <= hs_s1_d;
         vs_s1_q  <= vs_s1_d;
         de_s1_q  <= de_s1_d;
         rgb_s1_q <= rgb_s1_d;
         hs_s2_q  <= hs_s2_d;
         vs_s2_q  <= vs_s2_d;
         de_s2_q  <= de_s2_d;
      end
   end

   // Edge detection between the registered sample and its predecessor.
   always_comb begin
      vs_fall = vs_s2_q & ~vs_s1_q;
      hs_fall = hs_s2_q & ~hs_s1_q;
      de_rise = de_s1_q & ~de_s2_q;
      de_fall = de_s2_q & ~de_s1_q;
   end

   // Next-state and output decode for the frame/line tracker.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      hs_cnt_d     = hs_cnt_q;
      wr_en_d      = 1'b0;
      wr_x_d       = wr_x_q;
      wr_y_d       = wr_y_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      line_err_d   = 1'b0;
      frame_err_d  = 1'b0;
      locked_d     = locked_q;
      frame_cnt_d  = frame_cnt_q;
      line_start   = 1'b0;
      frame_end    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (vs_fall) begin
               state_d  = ST_WAIT_DE;
               x_d      = 10'd0;
               y_d      = 10'd0;
               hs_cnt_d = 2'd0;
            end
         end

         ST_WAIT_DE: begin
            // hsync activity before the first line is vertical blanking.
            if (de_rise) begin
               line_start = 1'b1;
            end
         end

         ST_LINE: begin
            if (de_s1_q) begin
               if (x_q < X_FULL) begin
                  wr_en_d   = 1'b1;
                  wr_x_d    = x_q;
                  wr_y_d    = y_q;
                  wr_data_d = rgb_s1_q;
               end
               if (x_q != X_SAT) begin
                  x_d = x_q + 10'd1;
               end
            end else if (de_fall) begin
               if (x_q != X_FULL) begin
                  line_err_d = 1'b1;
                  locked_d   = 1'b0;
                  state_d    = ST_IDLE;
               end else if (y_q == Y_LAST) begin
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 16'd1;
                  locked_d     = 1'b1;
                  frame_end    = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  y_d      = y_q + 10'd1;
                  hs_cnt_d = 2'd0;
                  state_d  = ST_GAP;
               end
            end
         end

         ST_GAP: begin
            // Saturating count: anything beyond one pulse is already an error.
            if (hs_fall && (hs_cnt_q != 2'd3)) begin
               hs_cnt_d = hs_cnt_q + 2'd1;
            end
            if (de_rise) begin
               if (hs_cnt_q == 2'd1) begin
                  line_start = 1'b1;
               end else begin
                  line_err_d = 1'b1;
                  locked_d   = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The first enabled cycle of a line is itself pixel 0.
      if (line_start) begin
         wr_en_d   = 1'b1;
         wr_x_d    = 10'd0;
         wr_y_d    = y_q;
         wr_data_d = rgb_s1_q;
         x_d       = 10'd1;
         state_d   = ST_LINE;
      end

      // vsync inside a frame restarts capture. A line that completed the
      // frame in this same cycle has already been credited, so that case
      // is a clean frame boundary rather than an error.
      if (vs_fall && (state_q != ST_IDLE)) begin
         wr_en_d   = 1'b0;
         wr_x_d    = wr_x_q;
         wr_y_d    = wr_y_q;
         wr_data_d = wr_data_q;
         if (!frame_end) begin
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
         end
         state_d  = ST_WAIT_DE;
         x_d      = 10'd0;
         y_d      = 10'd0;
         hs_cnt_d = 2'd0;
      end
   end

   // Tracker state and output registers.
   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         x_q          <= 10'd0;
         y_q          <= 10'd0;
         hs_cnt_q     <= 2'd0;
         wr_en_q      <= 1'b0;
         wr_x_q       <= 10'd0;
         wr_y_q       <= 10'd0;
         wr_data_q    <= 24'h0;
         frame_done_q <= 1'b0;
         locked_q     <= 1'b0;
         line_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         hs_cnt_q     <= hs_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_x_q       <= wr_x_d;
         wr_y_q       <= wr_y_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         locked_q     <= locked_d;
         line_err_q   <= line_err_d;
         frame_err_q  <= frame_err_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_x       = wr_x_q;
   assign wr_y       = wr_y_q;
   assign wr_data    = wr_data_q;
   assign frame_done = frame_done_q;
   assign locked     = locked_q;
   assign line_err   = line_err_q;
   assign frame_err  = frame_err_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_capture                                               |
// | Description : Randomized scoreboard bench for vga_capture on a reduced     |
// |               raster. A segment-level model predicts writes and pulses     |
// |               with their output cycle; a monitor compares them.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_capture;
   localparam int H = 12;
   localparam int V = 6;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_LINE = 2;
   localparam int M_GAP  = 3;

   logic        pclk  = 1'b0;
   logic        reset = 1'b1;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        valid = 1'b0;
   logic [7:0]  vga_r = 8'h0;
   logic [7:0]  vga_g = 8'h0;
   logic [7:0]  vga_b = 8'h0;
   logic        wr_en;
   logic [9:0]  wr_x;
   logic [9:0]  wr_y;
   logic [23:0] wr_data;
   logic        frame_done;
   logic        locked;
   logic        line_err;
   logic        frame_err;
   logic [15:0] frame_cnt;

   vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .pclk       (pclk),
      .reset      (reset),
      .hsync      (hsync),
      .vsync      (vsync),
      .valid      (valid),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .wr_en      (wr_en),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .locked     (locked),
      .line_err   (line_err),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt)
   );

   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int          x;
      int          y;
      logic [23:0] d;
      int          c;
   } wr_t;

   // kind: {frame_done, line_err, frame_err}
   typedef struct {
      logic [2:0]  kind;
      logic        lk;
      logic [15:0] cnt;
      int          c;
   } ev_t;

   wr_t wq[$];
   ev_t eq[$];

   int          total = 0;
   int          bad   = 0;
   int          zero_cyc = -1;
   bit          fin = 1'b0;
   logic [24:0] fix_pix = 25'd0;

   // Reference model state
   int          m_st  = M_IDLE;
   int          m_y   = 0;
   int          m_hs  = 0;
   logic        m_lk  = 1'b0;
   logic [15:0] m_cnt = 16'd0;

   task automatic push_ev(input logic [2:0] kind, input int c);
      ev_t e;
      e.kind = kind;
      e.lk   = m_lk;
      e.cnt  = m_cnt;
      e.c    = c;
      eq.push_back(e);
   endtask

   // One pixel-clock cycle of stimulus; the value belongs to cycle 'cyc'.
   task automatic step(input logic h, input logic v, input logic de,
                       input logic [23:0] d, input logic rst);
      @(posedge pclk);
      #1;
      hsync = h;
      vsync = v;
      valid = de;
      vga_r = d[23:16];
      vga_g = d[15:8];
      vga_b = d[7:0];
      reset = rst;
      if (rst) zero_cyc = cyc + 1;
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
   endtask

   task automatic hs_pulse();
      step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
      if (m_st == M_GAP) m_hs++;
      step(1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
      blank(2);
   endtask

   task automatic gap(input int k);
      blank(2);
      for (int i = 0; i < k; i++) hs_pulse();
      blank(2);
   endtask

   task automatic vs_seg();
      blank(1);
      step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      if (m_st != M_IDLE) begin
         m_lk = 1'b0;
         push_ev(3'b001, cyc + 2);
      end
      m_st = M_WAIT;
      m_y  = 0;
      step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
      blank(3);
      hs_pulse();
      blank(2);
   endtask

   // One enabled run of 'len' pixels, optionally with reset at pixel rst_at.
   task automatic line(input int len, input int rst_at);
      logic [23:0] d;
      int          c;
      wr_t         w;
      for (int i = 0; i < len; i++) begin
         d = 24'($urandom);
         if (i == 0 && fix_pix[24]) begin
            d       = fix_pix[23:0];
            fix_pix = 25'd0;
         end
         step(1'b1, 1'b1, 1'b1, d, (i == rst_at));
         c = cyc;
         if (i == rst_at) begin
            while (wq.size() > 0 && wq[wq.size()-1].c > c) wq.delete(wq.size()-1);
            while (eq.size() > 0 && eq[eq.size()-1].c > c) eq.delete(eq.size()-1);
            m_st  = M_IDLE;
            m_lk  = 1'b0;
            m_cnt = 16'd0;
         end else begin
            if (i == 0 && m_st == M_GAP && m_hs != 1) begin
               m_lk = 1'b0;
               m_st = M_IDLE;
               push_ev(3'b010, c + 2);
            end else if (i == 0 && (m_st == M_WAIT || m_st == M_GAP)) begin
               m_st = M_LINE;
            end
            if (m_st == M_LINE && i < H) begin
               w.x = i;
               w.y = m_y;
               w.d = d;
               w.c = c + 2;
               wq.push_back(w);
            end
         end
      end
      step(1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
      c = cyc;
      if (m_st == M_LINE) begin
         if (len != H) begin
            m_lk = 1'b0;
            m_st = M_IDLE;
            push_ev(3'b010, c + 2);
         end else if (m_y == V - 1) begin
            m_cnt = m_cnt + 16'd1;
            m_lk  = 1'b1;
            m_st  = M_IDLE;
            push_ev(3'b100, c + 2);
         end else begin
            m_y++;
            m_hs = 0;
            m_st = M_GAP;
         end
      end
   endtask

   // vsync, then nl lines; line bl gets length blen, the gap before line bg
   // carries gk hsync pulses, and line rl is hit by reset at pixel ra.
   task automatic frame(input int nl, input int bl, input int blen, input int bg,
                        input int gk, input int rl, input int ra);
      vs_seg();
      for (int l = 0; l < nl; l++) begin
         if (l > 0) gap((l == bg) ? gk : 1);
         line((l == bl) ? blen : H, (l == rl) ? ra : -1);
      end
      gap(1);
      blank(3);
   endtask

   // Monitor / scoreboard
   wr_t we;
   ev_t ee;
   always @(negedge pclk) begin
      if (cyc == zero_cyc) begin
         total++;
         if ({wr_en, wr_x, wr_y, wr_data, frame_done, locked, line_err, frame_err, frame_cnt} !== 70'd0) begin
            bad++;
            $display("FAIL reset_state cyc=%0d got en=%b x=%0d y=%0d data=%h done=%b lock=%b lerr=%b ferr=%b cnt=%0d need all zero",
                     cyc, wr_en, wr_x, wr_y, wr_data, frame_done, locked, line_err, frame_err, frame_cnt);
         end
      end

      while (wq.size() > 0 && wq[0].c < cyc) begin
         we = wq.pop_front();
         total++;
         bad++;
         $display("FAIL missing_write cyc=%0d got none need (%0d,%0d,%h)", we.c, we.x, we.y, we.d);
      end
      while (eq.size() > 0 && eq[0].c < cyc) begin
         ee = eq.pop_front();
         total++;
         bad++;
         $display("FAIL missing_pulse cyc=%0d got none need kind=%b", ee.c, ee.kind);
      end

      if (wr_en === 1'b1) begin
         total++;
         if (wq.size() == 0) begin
            bad++;
            $display("FAIL write cyc=%0d got (%0d,%0d,%h) need no write", cyc, wr_x, wr_y, wr_data);
         end else begin
            we = wq.pop_front();
            if (wr_x !== 10'(we.x) || wr_y !== 10'(we.y) || wr_data !== we.d || cyc != we.c) begin
               bad++;
               $display("FAIL write cyc=%0d got (%0d,%0d,%h) need (%0d,%0d,%h) at cyc %0d",
                        cyc, wr_x, wr_y, wr_data, we.x, we.y, we.d, we.c);
            end
         end
      end

      if (frame_done === 1'b1 || line_err === 1'b1 || frame_err === 1'b1) begin
         total++;
         if (eq.size() == 0) begin
            bad++;
            $display("FAIL pulse cyc=%0d got kind=%b need none", cyc, {frame_done, line_err, frame_err});
         end else begin
            ee = eq.pop_front();
            if ({frame_done, line_err, frame_err} !== ee.kind || locked !== ee.lk ||
                frame_cnt !== ee.cnt || cyc != ee.c) begin
               bad++;
               $display("FAIL pulse cyc=%0d got kind=%b lock=%b cnt=%0d need kind=%b lock=%b cnt=%0d at cyc %0d",
                        cyc, {frame_done, line_err, frame_err}, locked, frame_cnt,
                        ee.kind, ee.lk, ee.cnt, ee.c);
            end
         end
      end

      if (fin) begin
         total++;
         if (wq.size() != 0 || eq.size() != 0) begin
            bad++;
            $display("FAIL drain got writes=%0d pulses=%0d outstanding need 0", wq.size(), eq.size());
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got no completion need finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      step(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
      blank(4);

      // Joined mid-frame: no vsync seen, nothing captured.
      line(H, -1);
      gap(1);
      line(H, -1);
      gap(1);

      // First captured frame; its first pixel is a known value.
      fix_pix = {1'b1, 24'h123456};
      frame(V, -1, H, -1, 1, -1, 0);
      // Short line, then full relock.
      frame(V, 2, H - 1, -1, 1, -1, 0);
      frame(V, -1, H, -1, 1, -1, 0);
      // Long line.
      frame(V, 3, H + 1, -1, 1, -1, 0);
      // Early vsync after 3 lines, then a full frame.
      frame(3, -1, H, -1, 1, -1, 0);
      frame(V, -1, H, -1, 1, -1, 0);
      // Missing and extra hsync between lines.
      frame(V, -1, H, 2, 0, -1, 0);
      frame(V, -1, H, 4, 2, -1, 0);
      // Reset in the middle of a line, then recapture.
      frame(V, -1, H, -1, 1, 4, 5);
      frame(V, -1, H, -1, 1, -1, 0);

      for (int f = 0; f < 24; f++) begin
         int nl, bl, blen, bg, gk, rl, ra;
         nl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, V - 1)) : V;
         bl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V - 1)) : -1;
         case ($urandom_range(0, 3))
            0:       blen = H - 1;
            1:       blen = H + 1;
            2:       blen = H + 3;
            default: blen = 1;
         endcase
         bg = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, V - 1)) : -1;
         gk = ($urandom_range(0, 1) == 0) ? 0 : 2;
         rl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, V - 1)) : -1;
         ra = int'($urandom_range(0, H - 1));
         frame(nl, bl, blen, bg, gk, rl, ra);
      end

      blank(10);
      fin = 1'b1;
   end

endmodule
`default_nettype wire
